// File: rtl/pipe_ctrl_if.sv
// Run-control bundle between decode/debug and pipe_ctrl.
// master drives hazard/debug requests; slave (pipe_ctrl) returns pipeline strobes.
interface pipe_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_uses_rt;
   logic             ex_mem_read;
   logic [4:0]       ex_rt;
   logic             branch_taken;
   logic             halt_decoded;
   logic             step_mode;
   logic             step_req;
   logic             resume;
   logic             pipe_en;
   logic             pc_write;
   logic             if_id_write;
   logic             if_id_flush;
   logic             id_ex_bubble;
   logic             halted;
   logic [CNT_W-1:0] cycle_count;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, branch_taken,
             halt_decoded, step_mode, step_req, resume,
      input  pipe_en, pc_write, if_id_write, if_id_flush, id_ex_bubble,
             halted, cycle_count, stall_count
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, branch_taken,
             halt_decoded, step_mode, step_req, resume,
      output pipe_en, pc_write, if_id_write, if_id_flush, id_ex_bubble,
             halted, cycle_count, stall_count
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline run-control: load-use stall, branch flush, halt drain and debug single-step.
// Define PIPE_CTRL_STALL_CNT_EN to build the stall_count register.
module pipe_ctrl #(
   parameter int DRAIN_CYCLES = 4,
   parameter int CNT_W        = 32
) (
   input  logic       clk,
   input  logic       reset,
   pipe_ctrl_if.slave bus
);
   localparam int            DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

   typedef enum logic [2:0] {
      S_RUN,
      S_STEP_IDLE,
      S_STEP_ADV,
      S_DRAIN,
      S_HALTED
   } state_t;

   state_t           r_state;
   logic [DW-1:0]    r_drain_cnt;
   logic             r_pipe_en;
   logic             r_halted;
   logic [CNT_W-1:0] r_cycle_count;

   logic w_stall;
   logic w_draining;
   logic w_flush;

   // pipe_en/halted only change on state transitions, so they are set alongside r_state.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_drain_cnt <= '0;
         r_halted    <= 1'b0;
         if (bus.step_mode) begin
            r_state   <= S_STEP_IDLE;
            r_pipe_en <= 1'b0;
         end else begin
            r_state   <= S_RUN;
            r_pipe_en <= 1'b1;
         end
      end else begin
         case (r_state)
            S_RUN: begin
               if (bus.halt_decoded) begin
                  r_state     <= S_DRAIN;
                  r_drain_cnt <= DRAIN_LOAD;
               end else if (bus.step_mode) begin
                  r_state   <= S_STEP_IDLE;
                  r_pipe_en <= 1'b0;
               end
            end
            S_STEP_IDLE: begin
               if (!bus.step_mode) begin
                  r_state   <= S_RUN;
                  r_pipe_en <= 1'b1;
               end else if (bus.step_req) begin
                  r_state   <= S_STEP_ADV;
                  r_pipe_en <= 1'b1;
               end
            end
            S_STEP_ADV: begin
               if (bus.halt_decoded) begin
                  r_state     <= S_DRAIN;
                  r_drain_cnt <= DRAIN_LOAD;
               end else begin
                  r_state   <= S_STEP_IDLE;
                  r_pipe_en <= 1'b0;
               end
            end
            S_DRAIN: begin
               if (r_drain_cnt == '0) begin
                  r_state   <= S_HALTED;
                  r_pipe_en <= 1'b0;
                  r_halted  <= 1'b1;
               end else begin
                  r_drain_cnt <= r_drain_cnt - 1'b1;
               end
            end
            S_HALTED: begin
               if (bus.resume) begin
                  r_halted <= 1'b0;
                  if (bus.step_mode) begin
                     r_state   <= S_STEP_IDLE;
                     r_pipe_en <= 1'b0;
                  end else begin
                     r_state   <= S_RUN;
                     r_pipe_en <= 1'b1;
                  end
               end
            end
            default: begin
               r_state   <= S_RUN;
               r_pipe_en <= 1'b1;
               r_halted  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cycle_count <= '0;
      end else if (r_pipe_en) begin
         r_cycle_count <= r_cycle_count + CNT_W'(1);
      end
   end

   // Stall beats flush: a branch resolved against a stale operand must not redirect fetch.
   assign w_stall = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
                    ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));
   assign w_draining = (r_state == S_DRAIN);
   assign w_flush    = !w_stall && (bus.branch_taken || w_draining);

   assign bus.pipe_en      = r_pipe_en;
   assign bus.halted       = r_halted;
   assign bus.pc_write     = r_pipe_en && !w_stall && !w_draining;
   assign bus.if_id_write  = r_pipe_en && !w_stall && !w_flush;
   assign bus.if_id_flush  = r_pipe_en && w_flush;
   assign bus.id_ex_bubble = r_pipe_en && w_stall;
   assign bus.cycle_count  = r_cycle_count;

`ifdef PIPE_CTRL_STALL_CNT_EN
   logic [CNT_W-1:0] r_stall_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_count <= '0;
      end else if (r_pipe_en && w_stall) begin
         r_stall_count <= r_stall_count + CNT_W'(1);
      end
   end

   assign bus.stall_count = r_stall_count;
`else
   assign bus.stall_count = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl (DRAIN_CYCLES=4, CNT_W=4).
module tb_pipe_ctrl;
   localparam int CW = 4;
   // strobe vector: {pipe_en, pc_write, if_id_write, if_id_flush, id_ex_bubble, halted}
   localparam logic [5:0] NORM  = 6'b111000;
   localparam logic [5:0] STALL = 6'b100010;
   localparam logic [5:0] BRF   = 6'b110100;
   localparam logic [5:0] DRN   = 6'b100100;
   localparam logic [5:0] HLT   = 6'b000001;
   localparam logic [5:0] IDLE  = 6'b000000;

   typedef struct {
      string           tag;
      logic [5:0]      s;
      logic [CW-1:0]   cyc;
      logic [CW-1:0]   stl;
   } exp_t;

   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   logic [CW-1:0] m_cyc;
   logic [CW-1:0] m_stl;
   exp_t sb[$];

   pipe_ctrl_if #(.CNT_W(CW)) bus ();

   pipe_ctrl #(.DRAIN_CYCLES(4), .CNT_W(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_uses_rt = 1'b0;
      bus.ex_mem_read = 1'b0; bus.ex_rt = 5'd0; bus.branch_taken = 1'b0;
      bus.halt_decoded = 1'b0; bus.step_req = 1'b0; bus.resume = 1'b0;
   endtask

   task automatic do_reset(input logic mode);
      reset = 1'b1;
      bus.step_mode = mode;
      tick();
      reset = 1'b0;
      m_cyc = '0;
      m_stl = '0;
   endtask

   task automatic chk_val(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   // Push the expected cycle result, then pop and compare at the falling edge.
   task automatic expect_out(input string tag, input logic [5:0] s);
      exp_t e;
      logic [5:0] obs;
      sb.push_back('{tag: tag, s: s, cyc: m_cyc, stl: m_stl});
      @(negedge clk);
      e   = sb.pop_front();
      obs = {bus.pipe_en, bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble, bus.halted};
      checks++;
      assert (obs === e.s) else begin
         errors++;
         $error("FAIL %s strobes observed=%b expected=%b", e.tag, obs, e.s);
      end
      chk_val({e.tag, "_cyc"}, bus.cycle_count, e.cyc);
      chk_val({e.tag, "_stl"}, bus.stall_count, e.stl);
      $display("step %-14s strobes=%b cyc=%0d stl=%0d", e.tag, obs, bus.cycle_count, bus.stall_count);
      if (e.s[5]) m_cyc = m_cyc + 1'b1;
`ifdef PIPE_CTRL_STALL_CNT_EN
      if (e.s[1]) m_stl = m_stl + 1'b1;
`endif
   endtask

   initial begin
      logic [CW-1:0] stl_one;
`ifdef PIPE_CTRL_STALL_CNT_EN
      stl_one = 4'd1;
`else
      stl_one = 4'd0;
`endif
      clear_in();
      reset = 1'b1;
      bus.step_mode = 1'b0;
      do_reset(1'b0);

      // load-use hazards
      expect_out("reset_run", NORM); tick();
      bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd5; bus.id_rs = 5'd5;
      expect_out("ld_use_rs", STALL); tick();
      clear_in();
      expect_out("after_stall", NORM);
      chk_val("stall_cnt_one", bus.stall_count, stl_one);
      tick();
      bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd0; bus.id_rs = 5'd0;
      expect_out("ld_rt_zero", NORM); tick();
      bus.ex_rt = 5'd7; bus.id_rt = 5'd7; bus.id_rs = 5'd3; bus.id_uses_rt = 1'b1;
      expect_out("ld_use_rt", STALL); tick();
      bus.id_uses_rt = 1'b0;
      expect_out("ld_rt_unused", NORM); tick();

      // stall masks branch, then branch flushes
      bus.ex_rt = 5'd9; bus.id_rs = 5'd9; bus.branch_taken = 1'b1;
      expect_out("stall_branch", STALL); tick();
      clear_in(); bus.branch_taken = 1'b1;
      expect_out("branch_flush", BRF); tick();
      clear_in(); bus.resume = 1'b1;
      expect_out("resume_in_run", NORM); tick();
      clear_in();

      // halt drain
      bus.halt_decoded = 1'b1;
      expect_out("halt_dec", NORM); tick();
      bus.halt_decoded = 1'b0;
      for (int i = 0; i < 4; i++) begin
         expect_out("drain", DRN); tick();
      end
      expect_out("halted", HLT); tick();
      bus.step_req = 1'b1;
      expect_out("halted_hold", HLT); tick();
      bus.step_req = 1'b0; bus.resume = 1'b1;
      expect_out("resume_cyc", HLT); tick();
      bus.resume = 1'b0;
      expect_out("resumed_run", NORM); tick();

      // reset in the second drain cycle
      bus.halt_decoded = 1'b1;
      expect_out("halt_dec2", NORM); tick();
      bus.halt_decoded = 1'b0;
      expect_out("drain_c1", DRN); tick();
      reset = 1'b1;
      expect_out("drain_c2", DRN); tick();
      reset = 1'b0; m_cyc = '0; m_stl = '0;
      expect_out("rst_mid_drain", NORM); tick();

      // single step
      do_reset(1'b1);
      expect_out("rst_step", IDLE); tick();
      for (int p = 0; p < 3; p++) begin
         bus.step_req = 1'b1;
         expect_out("step_req", IDLE); tick();
         bus.step_req = 1'b0;
         expect_out("step_adv", NORM); tick();
         for (int w = 0; w < 3; w++) begin
            expect_out("step_wait", IDLE); tick();
         end
      end
      chk_val("step_cycles", bus.cycle_count, 4'd3);
      bus.step_req = 1'b1;
      expect_out("req_long_a", IDLE); tick();
      expect_out("req_long_b", NORM); tick();
      bus.step_req = 1'b0;
      expect_out("no_queue", IDLE); tick();
      bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd4; bus.id_rs = 5'd4; bus.step_req = 1'b1;
      expect_out("stall_gated", IDLE); tick();
      bus.step_req = 1'b0;
      expect_out("step_stall", STALL); tick();
      expect_out("step_stall_idle", IDLE); tick();
      clear_in();

      // reset during STEP_ADV
      bus.step_req = 1'b1;
      expect_out("pre_adv", IDLE); tick();
      bus.step_req = 1'b0; reset = 1'b1; bus.step_mode = 1'b0;
      expect_out("adv_in_rst", NORM); tick();
      reset = 1'b0; m_cyc = '0; m_stl = '0;
      expect_out("rst_mid_step", NORM); tick();

      // step_req with step_mode falling: mode wins
      bus.step_mode = 1'b1;
      expect_out("to_step", NORM); tick();
      bus.step_req = 1'b1; bus.step_mode = 1'b0;
      expect_out("req_mode_fall", IDLE); tick();
      bus.step_req = 1'b0;
      expect_out("mode_wins", NORM); tick();
      expect_out("mode_wins_run", NORM); tick();

      // counter wrap with CNT_W=4
      do_reset(1'b0);
      for (int k = 0; k < 17; k++) begin
         expect_out("wrap_run", NORM); tick();
      end
      chk_val("cycle_wrap", bus.cycle_count, 4'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
